intersection_phase_scheduler: RTL

//  Timed phase sequencer for a two-street intersection (street A, street B) with pedestrian walk phase.

---
 rtl/intersection_phase_scheduler.sv | 125 ++++++++++++
 1 files changed

// File: rtl/intersection_phase_scheduler.sv
// Two-street traffic light phase sequencer with min/max green arbitration and a pedestrian walk phase.
// Optional night flash mode is compiled in with INTERSECTION_NIGHT_FLASH_EN.
module intersection_phase_scheduler #(
  parameter int GREEN_MIN     = 4,
  parameter int GREEN_MAX     = 16,
  parameter int YELLOW_CYCLES = 2,
  parameter int ALLRED_CYCLES = 1,
  parameter int WALK_CYCLES   = 6,
  parameter int FLASH_HALF    = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       t_a,
  input  logic       t_b,
  input  logic       ped_req,
`ifdef INTERSECTION_NIGHT_FLASH_EN
  input  logic       night_mode,
`endif
  output logic [1:0] l_a,
  output logic [1:0] l_b,
  output logic       walk,
  output logic [2:0] phase
);

  localparam int CW = $clog2(GREEN_MAX + 2 * FLASH_HALF);
  localparam logic [CW-1:0] GMIN_L  = CW'(GREEN_MIN - 1);
  localparam logic [CW-1:0] GMAX_L  = CW'(GREEN_MAX - 1);
  localparam logic [CW-1:0] YEL_L   = CW'(YELLOW_CYCLES - 1);
  localparam logic [CW-1:0] AR_L    = CW'(ALLRED_CYCLES - 1);
  localparam logic [CW-1:0] WALK_L  = CW'(WALK_CYCLES - 1);
  localparam logic [CW-1:0] FLASH_L = CW'(2 * FLASH_HALF - 1);
  localparam logic [CW-1:0] FHALF   = CW'(FLASH_HALF);

  localparam logic [1:0] GRN = 2'b00, YEL = 2'b01, RED = 2'b10, DRK = 2'b11;

  typedef enum logic [2:0] {
    A_GREEN = 3'd0, A_YEL = 3'd1, AR_AB = 3'd2, B_GREEN = 3'd3,
    B_YEL   = 3'd4, AR_BA = 3'd5, WALK  = 3'd6, FLASH   = 3'd7
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q;
  logic            ped_pend_q, next_b_q;
  logic            night;
  logic            a_yield, b_yield;

`ifdef INTERSECTION_NIGHT_FLASH_EN
  assign night = night_mode;
`else
  assign night = 1'b0;
`endif

  // A green side yields once min green is served and the other side wants it,
  // or a pedestrian is waiting; contested greens run to the max.
  assign a_yield = (cnt_q >= GMIN_L) &&
                   ((t_b && !t_a) || (t_b && cnt_q == GMAX_L) || ped_pend_q);
  assign b_yield = (cnt_q >= GMIN_L) &&
                   ((t_a && !t_b) || (t_a && cnt_q == GMAX_L) || ped_pend_q);

  always_comb begin
    state_d = state_q;
    case (state_q)
      A_GREEN: if (a_yield) state_d = A_YEL;
      A_YEL:   if (cnt_q == YEL_L) state_d = AR_AB;
      AR_AB:   if (cnt_q == AR_L)
                 state_d = night ? FLASH : (ped_pend_q ? WALK : B_GREEN);
      B_GREEN: if (b_yield) state_d = B_YEL;
      B_YEL:   if (cnt_q == YEL_L) state_d = AR_BA;
      AR_BA:   if (cnt_q == AR_L)
                 state_d = night ? FLASH : (ped_pend_q ? WALK : A_GREEN);
      WALK:    if (cnt_q == WALK_L) state_d = next_b_q ? B_GREEN : A_GREEN;
`ifdef INTERSECTION_NIGHT_FLASH_EN
      FLASH:   if (cnt_q == FLASH_L && !night) state_d = AR_BA;
`endif
      default: state_d = A_GREEN;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= A_GREEN;
      cnt_q      <= '0;
      ped_pend_q <= 1'b0;
      next_b_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      if (state_d != state_q)
        cnt_q <= '0;
      else if (state_q == FLASH)
        cnt_q <= (cnt_q == FLASH_L) ? '0 : cnt_q + 1'b1;
      else if (cnt_q != GMAX_L)
        cnt_q <= cnt_q + 1'b1;
      // Entering walk serves the request; a press during walk queues the next one.
      if (state_d == WALK && state_q != WALK)
        ped_pend_q <= 1'b0;
      else if (state_q != FLASH)
        ped_pend_q <= ped_pend_q | ped_req;
      if (state_q == AR_AB)
        next_b_q <= 1'b1;
      else if (state_q == AR_BA)
        next_b_q <= 1'b0;
    end
  end

  always_comb begin
    l_a  = RED;
    l_b  = RED;
    walk = 1'b0;
    case (state_q)
      A_GREEN: l_a = GRN;
      A_YEL:   l_a = YEL;
      B_GREEN: l_b = GRN;
      B_YEL:   l_b = YEL;
      WALK:    walk = 1'b1;
      FLASH: begin
        l_a = (cnt_q < FHALF) ? YEL : DRK;
        l_b = (cnt_q < FHALF) ? YEL : DRK;
      end
      default: ;
    endcase
  end

  assign phase = state_q;

endmodule
